// File: rtl/opamp_chan_sequencer_if.sv
// Config bus between the pin-driven config port and the opamp channel sequencer.
interface opamp_chan_sequencer_if;
  logic [7:0] cfg_data;
  logic       cfg_strobe;
  logic [7:0] rd_data;

  modport master (
    output cfg_data,
    output cfg_strobe,
    input  rd_data
  );

  modport slave (
    input  cfg_data,
    input  cfg_strobe,
    output rd_data
  );
endinterface

// File: rtl/opamp_chan_sequencer.sv
// Power-up sequencer and trim/mask register bank for on-die opamp channels.
// Optional registered readback on rd_data is enabled by defining OPAMP_SEQ_READBACK_EN.
module opamp_chan_sequencer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TRIM_W       = 3,
  parameter int unsigned SETTLE_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       start,
  input  logic                       stop,
  opamp_chan_sequencer_if.slave      cfg,
  output logic [NUM_CH-1:0]          ch_en,
  output logic [NUM_CH*TRIM_W-1:0]   ch_trim,
  output logic                       busy,
  output logic                       ready,
  output logic                       err,
  output logic [2:0]                 cur_ch
);

  typedef enum logic [1:0] {StIdle, StStep, StSettle, StRun} state_e;

  state_e              state_q;
  logic [NUM_CH-1:0]   ch_en_q;
  logic [2:0]          cur_ch_q;
  logic [7:0]          cnt_q;
  logic [TRIM_W-1:0]   trim_q [NUM_CH];
  logic [NUM_CH-1:0]   mask_q;
  logic [4:0]          settle_q;
  logic                err_q;
  logic                strobe_q;

  logic [2:0]          addr;
  logic [4:0]          payload;
  logic                strobe_edge;
  logic                wr_ok;
  logic                wr_rej;
  logic                cur_mask;
  logic [NUM_CH-1:0]   cur_onehot;
  logic                last_ch;
  logic                abort;

  assign addr        = cfg.cfg_data[7:5];
  assign payload     = cfg.cfg_data[4:0];
  assign strobe_edge = cfg.cfg_strobe & ~strobe_q;
  assign wr_ok       = strobe_edge & ena & (state_q == StIdle);
  assign wr_rej      = strobe_edge & ~(ena & (state_q == StIdle));
  assign last_ch     = (cur_ch_q == 3'(NUM_CH - 1));
  assign abort       = (state_q != StIdle) & (stop | ~ena);

  // Decode cur_ch by comparison so no select is wider than the channel vector.
  always_comb begin
    cur_mask   = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_ch_q == 3'(i)) begin
        cur_mask      = mask_q[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ch_trim = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_trim[i*TRIM_W +: TRIM_W] = trim_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      mask_q   <= '1;
      settle_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        trim_q[i] <= '0;
      end
    end else begin
      strobe_q <= cfg.cfg_strobe;
      if (wr_rej) begin
        err_q <= 1'b1;
      end
      if (wr_ok) begin
        if (addr == 3'd7) begin
          settle_q <= payload;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (addr == 3'(i)) begin
            trim_q[i] <= payload[TRIM_W-1:0];
            mask_q[i] <= payload[4];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ch_en_q  <= '0;
      cur_ch_q <= '0;
      cnt_q    <= '0;
    end else if (abort) begin
      state_q  <= StIdle;
      ch_en_q  <= '0;
      cur_ch_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && ena && !stop) begin
            state_q  <= StStep;
            cur_ch_q <= '0;
          end
        end
        StStep: begin
          if (cur_mask) begin
            ch_en_q <= ch_en_q | cur_onehot;
            cnt_q   <= {3'b000, settle_q} << SETTLE_SHIFT;
            state_q <= StSettle;
          end else if (last_ch) begin
            state_q <= StRun;
          end else begin
            cur_ch_q <= cur_ch_q + 3'd1;
            state_q  <= StStep;
          end
        end
        StSettle: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (last_ch) begin
            state_q <= StRun;
          end else begin
            cur_ch_q <= cur_ch_q + 3'd1;
            state_q  <= StStep;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign ch_en  = ch_en_q;
  assign cur_ch = cur_ch_q;
  assign err    = err_q;
  assign busy   = (state_q == StStep) || (state_q == StSettle);
  assign ready  = (state_q == StRun);

`ifdef OPAMP_SEQ_READBACK_EN
  logic [7:0] rd_q;
  logic [7:0] rd_next;

  // Show the post-edge contents: new value if the write lands, old value if rejected.
  always_comb begin
    rd_next = 8'h00;
    if (addr == 3'd7) begin
      rd_next = {3'b000, (wr_ok ? payload : settle_q)};
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == 3'(i)) begin
        rd_next = wr_ok ? {payload[4], 3'b000, 4'(payload[TRIM_W-1:0])}
                        : {mask_q[i], 3'b000, 4'(trim_q[i])};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= 8'h00;
    end else if (strobe_edge) begin
      rd_q <= rd_next;
    end
  end

  assign cfg.rd_data = rd_q;
`else
  assign cfg.rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_opamp_chan_sequencer.sv
// Scoreboard bench: stimulus queues expected output snapshots with their cycle, monitor checks.
module tb_opamp_chan_sequencer;

`ifdef OPAMP_SEQ_READBACK_EN
  localparam bit RdEn = 1'b1;
`else
  localparam bit RdEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  en;
    logic        busy;
    logic        ready;
    logic        err;
    logic [2:0]  cur;
    logic [11:0] trim;
    logic [7:0]  rd;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, stop;
  logic [3:0]  ch_en;
  logic [11:0] ch_trim;
  logic        busy, ready, err;
  logic [2:0]  cur_ch;

  opamp_chan_sequencer_if cfg_bus ();

  opamp_chan_sequencer #(
    .NUM_CH      (4),
    .TRIM_W      (3),
    .SETTLE_SHIFT(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (start),
    .stop   (stop),
    .cfg    (cfg_bus.slave),
    .ch_en  (ch_en),
    .ch_trim(ch_trim),
    .busy   (busy),
    .ready  (ready),
    .err    (err),
    .cur_ch (cur_ch)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    at_q[$];
  snap_t want_q[$];
  snap_t want, last_want, snap, prev, w;
  int    a;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb snap = {ch_en, busy, ready, err, cur_ch, ch_trim, cfg_bus.rd_data};

  // Monitor: every change of the observable outputs must match the next queued snapshot.
  always @(negedge clk) begin
    if (snap !== prev) begin
      if (want_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_change: got %h at cyc %0d, required no change", snap, cyc);
      end else begin
        w = want_q.pop_front();
        a = at_q.pop_front();
        n_cmp += 2;
        if (snap !== w) begin
          n_fail++;
          $display("FAIL snapshot@%0d: got %h required %h", cyc, snap, w);
        end
        if (a != cyc) begin
          n_fail++;
          $display("FAIL event_time: got cyc %0d required cyc %0d (snap %h)", cyc, a, w);
        end
      end
      prev = snap;
    end
  end

  task automatic push(input int at);
    if (want !== last_want) begin
      at_q.push_back(at);
      want_q.push_back(want);
      last_want = want;
    end
  endtask

  task automatic set_rd(input logic [7:0] v);
    want.rd = RdEn ? v : 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    cfg_bus.cfg_data   = d;
    cfg_bus.cfg_strobe = 1'b1;
    tick(1);
    cfg_bus.cfg_strobe = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic stop_to_idle();
    want.en = 4'h0; want.busy = 1'b0; want.ready = 1'b0; want.cur = 3'd0;
    push(cyc + 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_bus.cfg_data = 8'h15; cfg_bus.cfg_strobe = 1'b1;
    want = '0;
    push(1);
    tick(3);
    rst_n = 1'b1;
    cfg_bus.cfg_strobe = 1'b0;
    tick(1);
    // One rising edge with strobe then held high: a single write of trim0=5.
    want.trim = 12'h005; set_rd(8'h85); push(cyc + 1);
    cfg_bus.cfg_strobe = 1'b1;
    tick(3);
    cfg_bus.cfg_strobe = 1'b0;
    tick(2);

    // settle=3 -> load 12, spacing 14, all masks set.
    set_rd(8'h03); push(cyc + 1); wr(8'hE3);
    n = cyc;
    want.busy = 1'b1; want.cur = 3'd0; push(n + 1);
    want.en = 4'b0001; push(n + 2);
    for (int k = 1; k < 4; k++) begin
      want.cur = 3'(k); push(n + 1 + 14 * k);
      want.en[k] = 1'b1; push(n + 2 + 14 * k);
    end
    want.busy = 1'b0; want.ready = 1'b1; push(n + 57);
    pulse_start();
    tick(60);

    // Write in RUN is rejected; readback shows the untouched channel 0.
    want.err = 1'b1; set_rd(8'h85); push(cyc + 1); wr(8'h07);
    stop_to_idle();

    // Mask channel 1, settle=0.
    set_rd(8'h00); push(cyc + 1); wr(8'h20);
    push(cyc + 1); wr(8'hE0);
    n = cyc;
    want.busy = 1'b1; want.cur = 3'd0; push(n + 1);
    want.en = 4'b0001; push(n + 2);
    want.cur = 3'd1; push(n + 3);
    want.cur = 3'd2; push(n + 4);
    want.en = 4'b0101; push(n + 5);
    want.cur = 3'd3; push(n + 6);
    want.en = 4'b1101; push(n + 7);
    want.busy = 1'b0; want.ready = 1'b1; push(n + 8);
    pulse_start();
    tick(10);
    stop_to_idle();

    // settle=1 -> load 4; stop during SETTLE of channel 2, then replay.
    set_rd(8'h01); push(cyc + 1); wr(8'hE1);
    n = cyc;
    want.busy = 1'b1; want.cur = 3'd0; push(n + 1);
    want.en = 4'b0001; push(n + 2);
    want.cur = 3'd1; push(n + 7);
    want.cur = 3'd2; push(n + 8);
    want.en = 4'b0101; push(n + 9);
    pulse_start();
    tick(9);
    want.en = 4'h0; want.busy = 1'b0; want.cur = 3'd0; push(cyc + 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    n = cyc;
    want.busy = 1'b1; want.cur = 3'd0; push(n + 1);
    want.en = 4'b0001; push(n + 2);
    want.cur = 3'd1; push(n + 7);
    want.cur = 3'd2; push(n + 8);
    want.en = 4'b0101; push(n + 9);
    want.cur = 3'd3; push(n + 14);
    want.en = 4'b1101; push(n + 15);
    want.busy = 1'b0; want.ready = 1'b1; push(n + 20);
    pulse_start();
    tick(22);
    stop_to_idle();

    // start with stop in IDLE: nothing may change.
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(3);

    // Readback writes: channel 2 trim 6 mask 0, then settle 31.
    want.trim = 12'h185; set_rd(8'h06); push(cyc + 1); wr(8'h4E);
    set_rd(8'h1F); push(cyc + 1); wr(8'hFF);

    // Reset in the middle of a sequence.
    n = cyc;
    want.busy = 1'b1; want.cur = 3'd0; push(n + 1);
    want.en = 4'b0001; push(n + 2);
    pulse_start();
    tick(4);
    want = '0; push(cyc + 1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // ena low rejects writes and ignores start.
    ena = 1'b0;
    want.err = 1'b1; set_rd(8'h80); push(cyc + 1); wr(8'h13);
    pulse_start();
    tick(2);
    ena = 1'b1;
    set_rd(8'h00); push(cyc + 1); wr(8'hE0);

    // ena drop aborts a running sequence.
    n = cyc;
    want.busy = 1'b1; want.cur = 3'd0; push(n + 1);
    want.en = 4'b0001; push(n + 2);
    pulse_start();
    tick(1);
    want.en = 4'h0; want.busy = 1'b0; want.cur = 3'd0; push(cyc + 1);
    ena = 1'b0;
    tick(1);
    ena = 1'b1;
    tick(5);

    #1;
    while (want_q.size() != 0) begin
      w = want_q.pop_front();
      a = at_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_event: got none required %h at cyc %0d", w, a);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/opamp_chan_sequencer.md
Name: opamp_chan_sequencer

Overview:
Digital power-up sequencer and trim register bank for NUM_CH on-die opamp channels in a Tiny Tapeout analog tile. A byte-wide config port, driven from dedicated pins, writes per-channel trim and mask values and a global settle delay. On start, the block enables the unmasked channels one at a time, in index order, with a programmable settle interval between them. It then reports ready. ch_en and ch_trim drive the analog channel enable and bias-trim switches.

Parameters:
NUM_CH, 4, number of opamp channels (1..6).
TRIM_W, 3, trim bits per channel (1..4).
SETTLE_SHIFT, 2, left shift applied to the 5-bit settle value (0..3).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
ena  in  1  tile enable; low acts as stop and blocks writes
cfg_data  in  8  [7:5] address, [4:0] payload
cfg_strobe  in  1  write strobe, level from pin, edge-detected internally
start  in  1  begin sequencing (sampled only in IDLE)
stop  in  1  abort or shut down
ch_en  out  NUM_CH  per-channel enable
ch_trim  out  NUM_CH*TRIM_W  packed trims; channel i occupies [i*TRIM_W +: TRIM_W]
busy  out  1  high in STEP or SETTLE
ready  out  1  high in RUN
err  out  1  sticky flag: write rejected
cur_ch  out  3  channel index currently being sequenced
rd_data  out  8  readback (see Optional Feature)

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE.
  - ch_en=0, trim regs=0, mask regs=all 1, settle=0.
  - cur_ch=0, err=0, busy=0, ready=0, rd_data=0.
  - Strobe-edge history reg=0.
- Register writes:
  - A write occurs when cfg_strobe=1 now and was 0 on the previous cycle, with ena=1 and state IDLE.
  - The target register updates at that same clk edge; it is visible on outputs the next cycle.
  - Address a < NUM_CH: trim[a] = payload[TRIM_W-1:0]; mask[a] = payload[4].
  - Address 7: settle = payload[4:0].
  - Other addresses: ignored, no error.
- Write rejection: a strobe edge while the state is not IDLE, or while ena=0, sets err=1 and changes no register. err clears only on reset.
- FSM states: IDLE, STEP, SETTLE, RUN.
  - IDLE: start=1 and ena=1 and stop=0 -> STEP with cur_ch=0.
  - STEP, mask[cur_ch]=1: set ch_en[cur_ch]; load cnt = settle << SETTLE_SHIFT; go to SETTLE.
  - STEP, mask[cur_ch]=0: advance (1 cycle).
  - SETTLE, cnt != 0: cnt decrements by 1.
  - SETTLE, cnt == 0: advance.
  - Advance: if cur_ch == NUM_CH-1 go to RUN, else increment cur_ch and go to STEP.
  - RUN: holds state; ch_en is unchanged.
- Timing: the rise of ch_en for adjacent unmasked channels is spaced (settle << SETTLE_SHIFT) + 2 cycles. Each masked channel in between adds 1 cycle.
- All masks 0: RUN is reached NUM_CH+1 cycles after start is sampled, with ch_en=0.
- stop=1 or ena=0 in any non-IDLE state:
  - Next edge: state IDLE, ch_en=0, cur_ch=0.
  - Trim, mask and settle registers are retained.
- Simultaneous events:
  - stop has priority over start.
  - start outside IDLE is ignored and does not set err.
- Reset mid-sequence returns to IDLE with all outputs at their reset values.
- Counter width is 8 bits; the maximum load is 31<<3 = 248, so it cannot overflow.

Optional Feature:
- Macro OPAMP_SEQ_READBACK_EN.
- When defined, rd_data is a registered readback of the register last addressed by a strobe edge, accepted or rejected. It updates one cycle after the edge.
  - Channel address: rd_data = {mask, zero pad, trim}, with trim zero-extended into [3:0].
  - Address 7: rd_data = {3'b0, settle}.
  - Unused address: rd_data = 8'h00.
- When undefined, rd_data is constant 0 and the readback logic is absent.

Test Plan:
1. Reset with strobe held high, then a strobe low->high edge writing 8'h15 (addr 0, mask 1, trim 5) -> exactly one write occurs; ch_trim[2:0]=5; err=0.
2. Defaults plus a write of 8'hE3 (settle=3), then a 1-cycle start -> busy=1; ch_en[0] rises 2 cycles after start is sampled; ch_en[1..3] follow at 14-cycle spacing; ready=1 two cycles after the final SETTLE count completes.
3. Write 8'h20 (mask[1]=0), settle=0, start -> ch_en sequence 0, 2, 3 with rises at +2, +5, +7 cycles; ch_en[1] stays 0 throughout.
4. stop asserted while in SETTLE for channel 2 -> next cycle ch_en=0, busy=0, state IDLE; a following start replays the full sequence using the retained configuration.
5. Strobe edge during RUN -> err=1 and registers unchanged; start and stop asserted together in IDLE -> stays in IDLE.
6. With OPAMP_SEQ_READBACK_EN defined, write 8'h4E (addr 2, mask 0, trim 6) -> rd_data=8'h06 one cycle later; write 8'hFF -> rd_data=8'h1F.
